// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: decode-side and instruction-memory-side signals of the fetch queue.
// slave = the fetch queue itself, master = whoever drives decode control and memory.
interface if_fetch_queue_if #(
   parameter int unsigned PC_W  = 9,
   parameter int unsigned INS_W = 32,
   parameter int unsigned DEPTH = 4
);
   logic                     stall;
   logic                     redirect;
   logic [PC_W-1:0]          redirect_pc;
   logic                     imem_req;
   logic [PC_W-1:0]          imem_addr;
   logic                     imem_gnt;
   logic [INS_W-1:0]         imem_rdata;
   logic                     instr_valid;
   logic [INS_W-1:0]         instr;
   logic [PC_W-1:0]          instr_pc;
   logic                     halted;
   logic [$clog2(DEPTH):0]   occupancy;

   modport slave (
      input  stall, redirect, redirect_pc, imem_gnt, imem_rdata,
      output imem_req, imem_addr, instr_valid, instr, instr_pc, halted, occupancy
   );

   modport master (
      output stall, redirect, redirect_pc, imem_gnt, imem_rdata,
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted, occupancy
   );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: owns the fetch PC, issues 1-cycle-latency imem requests, buffers words in a prefetch FIFO.
// Optional FETCH_BYPASS_EN: a response arriving at an empty FIFO is forwarded straight to decode.
module if_fetch_queue #(
   parameter int unsigned PC_W  = 9,
   parameter int unsigned INS_W = 32,
   parameter int unsigned DEPTH = 4
) (
   input logic             clk,
   input logic             reset,
   if_fetch_queue_if.slave bus
);
   localparam int unsigned AW     = $clog2(DEPTH);
   localparam int unsigned CW     = AW + 1;
   localparam int unsigned INFL_W = CW + 1;
   localparam logic [6:0]  HALT_OP = 7'h7F;

   logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic             pend_q, pend_d;
   logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
   logic             halted_q, halted_d;
   logic [INS_W-1:0] ins_mem_q [DEPTH];
   logic [PC_W-1:0]  pc_mem_q  [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   logic [INFL_W-1:0] inflight;
   logic              req, grant, push, wr_en, pop, fifo_pop, head_valid, out_valid;

   assign inflight   = {1'b0, count_q} + {{CW{1'b0}}, pend_q};
   // Requests are gated by reset so nothing is issued while the block is held in reset.
   assign req        = reset && !halted_q && !bus.redirect && (inflight < INFL_W'(DEPTH));
   assign grant      = req && bus.imem_gnt;
   // A response is dropped when flushed by redirect or when it follows the halt word.
   assign push       = pend_q && !bus.redirect && !halted_q;
   assign head_valid = (count_q != '0);
   assign pop        = out_valid && !bus.stall && !bus.redirect;
   assign fifo_pop   = pop && head_valid;

`ifdef FETCH_BYPASS_EN
   logic bypass;
   assign bypass    = push && !head_valid;
   assign out_valid = head_valid || bypass;
   assign wr_en     = push && !(bypass && pop);
   assign bus.instr    = bypass ? bus.imem_rdata : ins_mem_q[rd_ptr_q];
   assign bus.instr_pc = bypass ? pend_pc_q : pc_mem_q[rd_ptr_q];
`else
   assign out_valid = head_valid;
   assign wr_en     = push;
   assign bus.instr    = ins_mem_q[rd_ptr_q];
   assign bus.instr_pc = pc_mem_q[rd_ptr_q];
`endif

   assign bus.instr_valid = out_valid;
   assign bus.imem_req    = req;
   assign bus.imem_addr   = fetch_pc_q;
   assign bus.halted      = halted_q;
   assign bus.occupancy   = count_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      pend_d     = grant;
      pend_pc_d  = pend_pc_q;
      halted_d   = halted_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (bus.redirect) begin
         fetch_pc_d = {bus.redirect_pc[PC_W-1:2], 2'b00};
         halted_d   = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + PC_W'(4);
            pend_pc_d  = fetch_pc_q;
         end
         if (push && (bus.imem_rdata[6:0] == HALT_OP)) halted_d = 1'b1;
         if (wr_en)    wr_ptr_d = wr_ptr_q + 1'b1;
         if (fifo_pop) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({wr_en, fifo_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= '0;
         pend_q     <= 1'b0;
         pend_pc_q  <= '0;
         halted_q   <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ins_mem_q[i] <= '0;
            pc_mem_q[i]  <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pend_q     <= pend_d;
         pend_pc_q  <= pend_pc_d;
         halted_q   <= halted_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         if (wr_en && !bus.redirect) begin
            ins_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pc_mem_q[wr_ptr_q]  <= pend_pc_q;
         end
      end
   end
endmodule
